inst_decode_stage: RTL and testbench

- Registered decode stage directly downstream of instruction fetch.
- Accepts the 32-bit instruction word over a valid/ready handshake and splits it into fields.
- Decodes the MIPS-subset opcode/funct into registered control signals; Branch and Jump are returned to fetch.
- Squashes the slot after a taken-path instruction (beq/j), halts on an illegal instruction, and counts decoded instructions.

---
 rtl/inst_decode_stage.sv | 253 +++++++++++++++++++++++++
 tb/tb_inst_decode_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_stage.sv
// -----------------------------------------------------------------------------
// inst_decode_stage
//
// Registered instruction-decode stage that sits directly after instruction
// fetch. It takes a 32-bit MIPS-subset instruction word over a valid/ready
// handshake. The word is split into its fields. The opcode/funct pair is
// decoded into registered control signals. Branch and Jump are returned to
// fetch.
//
// After a beq or j, the stage squashes the next accepted slot. It halts on an
// illegal instruction, and it counts every instruction loaded with IdValid=1.
//
// Optional build macro:
//   DELAY_SLOT_EN  - when defined, the word after beq/j is not squashed. It is
//                    treated as a branch delay slot: decoded, counted and
//                    checked for legality like any other word. When undefined,
//                    the SQUASH state is used as described above.
//
// Parameters:
//   CNT_W          - width of DecodeCount (wraps modulo 2^CNT_W)
//
// Ports:
//   Clock          in   rising-edge clock for all state
//   Reset          in   synchronous, active-high reset
//   Inst[31:0]     in   instruction word from fetch
//   InstValid      in   Inst is valid this cycle
//   InstReady      out  stage can accept Inst (!Stall && not halted)
//   Stall          in   downstream hold; every register keeps its value
//   IdValid        out  ID register holds a real, decodable instruction
//   Op/Rs/Rt/Rd/Funct/Imm16/Target
//                  out  raw fields of the registered instruction word
//   RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump
//                  out  control signals (0 whenever IdValid=0)
//   ALUOp[1:0]     out  ALU operation class
//   Illegal        out  sticky illegal-instruction flag (cleared by Reset only)
//   DecodeCount    out  number of instructions loaded with IdValid=1
// -----------------------------------------------------------------------------
module inst_decode_stage #(
    parameter int CNT_W = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      Inst,
    input  logic             InstValid,
    output logic             InstReady,
    input  logic             Stall,
    output logic             IdValid,
    output logic [5:0]       Op,
    output logic [4:0]       Rs,
    output logic [4:0]       Rt,
    output logic [4:0]       Rd,
    output logic [5:0]       Funct,
    output logic [15:0]      Imm16,
    output logic [25:0]      Target,
    output logic             RegDst,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             Branch,
    output logic             Jump,
    output logic [1:0]       ALUOp,
    output logic             Illegal,
    output logic [CNT_W-1:0] DecodeCount
);

    // Opcodes recognised by this stage.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    // R-type funct codes recognised by this stage.
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    // Control bundle packing:
    //   {RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp[1:0]}
    localparam int CTRL_W = 10;

    localparam logic [CTRL_W-1:0] CTRL_RTYPE = 10'b1_0_0_1_0_0_0_0_10;
    localparam logic [CTRL_W-1:0] CTRL_LW    = 10'b0_1_1_1_1_0_0_0_00;
    localparam logic [CTRL_W-1:0] CTRL_SW    = 10'b0_1_0_0_0_1_0_0_00;
    localparam logic [CTRL_W-1:0] CTRL_BEQ   = 10'b0_0_0_0_0_0_1_0_01;
    localparam logic [CTRL_W-1:0] CTRL_J     = 10'b0_0_0_0_0_0_0_1_00;
    localparam logic [CTRL_W-1:0] CTRL_ADDI  = 10'b0_1_0_1_0_0_0_0_00;
    localparam logic [CTRL_W-1:0] CTRL_ORI   = 10'b0_1_0_1_0_0_0_0_11;

    // Bit positions of the control-flow bits inside the bundle.
    localparam int CTRL_BRANCH_BIT = 3;
    localparam int CTRL_JUMP_BIT   = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALT   = 2'd2
    } state_t;

    // Returns {legal, control bundle}.
    // Illegal encodings return an all-zero control bundle.
    function automatic logic [CTRL_W:0] decode_ctrl(input logic [5:0] op,
                                                    input logic [5:0] funct);
        logic [CTRL_W:0] res;
        res = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT:
                        res = {1'b1, CTRL_RTYPE};
                    default:
                        res = '0;
                endcase
            end
            OP_LW:   res = {1'b1, CTRL_LW};
            OP_SW:   res = {1'b1, CTRL_SW};
            OP_BEQ:  res = {1'b1, CTRL_BEQ};
            OP_J:    res = {1'b1, CTRL_J};
            OP_ADDI: res = {1'b1, CTRL_ADDI};
            OP_ORI:  res = {1'b1, CTRL_ORI};
            default: res = '0;
        endcase
        return res;
    endfunction

    // Stage p1 registers (the ID register).
    logic [31:0]       word_p1;
    logic              vld_p1;
    logic [CTRL_W-1:0] ctrl_p1;
    logic              illegal_p1;
    logic [CNT_W-1:0]  count_p1;
    state_t            state_p1;

    // Next-state values.
    logic [31:0]       word_nxt;
    logic              vld_nxt;
    logic [CTRL_W-1:0] ctrl_nxt;
    logic              illegal_nxt;
    logic [CNT_W-1:0]  count_nxt;
    state_t            state_nxt;

    logic              accept;
    logic [CTRL_W:0]   dec;
    logic              dec_legal;
    logic [CTRL_W-1:0] dec_ctrl;
    logic              dec_redirect;

    assign InstReady    = !Stall && (state_p1 != HALT);
    assign accept       = InstValid && InstReady;

    assign dec          = decode_ctrl(Inst[31:26], Inst[5:0]);
    assign dec_legal    = dec[CTRL_W];
    assign dec_ctrl     = dec[CTRL_W-1:0];
    assign dec_redirect = dec_ctrl[CTRL_BRANCH_BIT] | dec_ctrl[CTRL_JUMP_BIT];

    always_comb begin
        // Default: hold everything (covers Stall=1).
        word_nxt    = word_p1;
        vld_nxt     = vld_p1;
        ctrl_nxt    = ctrl_p1;
        illegal_nxt = illegal_p1;
        count_nxt   = count_p1;
        state_nxt   = state_p1;

        if (!Stall) begin
            // Without an accept a bubble is loaded.
            // The fields keep the last word they captured.
            vld_nxt  = 1'b0;
            ctrl_nxt = '0;

            if (accept) begin
                // The fields always capture the raw word.
                // This includes squashed and illegal words.
                word_nxt = Inst;
                case (state_p1)
                    RUN: begin
                        if (!dec_legal) begin
                            illegal_nxt = 1'b1;
                            state_nxt   = HALT;
                        end else begin
                            vld_nxt   = 1'b1;
                            ctrl_nxt  = dec_ctrl;
                            count_nxt = count_p1 + CNT_W'(1);
`ifdef DELAY_SLOT_EN
                            state_nxt = RUN;
`else
                            state_nxt = dec_redirect ? SQUASH : RUN;
`endif
                        end
                    end
                    // The squashed slot is dropped without any legality check.
                    SQUASH: state_nxt = RUN;
                    default: state_nxt = state_p1;
                endcase
            end
        end
    end

`ifdef DELAY_SLOT_EN
    // A delay slot does not care whether the word redirects fetch.
    logic unused_redirect;
    assign unused_redirect = dec_redirect;
`endif

    // ---- stage p1: ID register ----
    always_ff @(posedge Clock) begin
        if (Reset) begin
            word_p1    <= '0;
            vld_p1     <= 1'b0;
            ctrl_p1    <= '0;
            illegal_p1 <= 1'b0;
            count_p1   <= '0;
            state_p1   <= RUN;
        end else begin
            word_p1    <= word_nxt;
            vld_p1     <= vld_nxt;
            ctrl_p1    <= ctrl_nxt;
            illegal_p1 <= illegal_nxt;
            count_p1   <= count_nxt;
            state_p1   <= state_nxt;
        end
    end

    assign IdValid     = vld_p1;
    assign Op          = word_p1[31:26];
    assign Rs          = word_p1[25:21];
    assign Rt          = word_p1[20:16];
    assign Rd          = word_p1[15:11];
    assign Funct       = word_p1[5:0];
    assign Imm16       = word_p1[15:0];
    assign Target      = word_p1[25:0];

    assign RegDst      = ctrl_p1[9];
    assign ALUSrc      = ctrl_p1[8];
    assign MemToReg    = ctrl_p1[7];
    assign RegWrite    = ctrl_p1[6];
    assign MemRead     = ctrl_p1[5];
    assign MemWrite    = ctrl_p1[4];
    assign Branch      = ctrl_p1[3];
    assign Jump        = ctrl_p1[2];
    assign ALUOp       = ctrl_p1[1:0];

    assign Illegal     = illegal_p1;
    assign DecodeCount = count_p1;

endmodule

// File: tb/tb_inst_decode_stage.sv
module tb_inst_decode_stage;

    localparam int CNT_W = 4;

    logic             Clock = 1'b0;
    logic             Reset;
    logic [31:0]      Inst;
    logic             InstValid;
    logic             InstReady;
    logic             Stall;
    logic             IdValid;
    logic [5:0]       Op;
    logic [4:0]       Rs;
    logic [4:0]       Rt;
    logic [4:0]       Rd;
    logic [5:0]       Funct;
    logic [15:0]      Imm16;
    logic [25:0]      Target;
    logic             RegDst, ALUSrc, MemToReg, RegWrite;
    logic             MemRead, MemWrite, Branch, Jump;
    logic [1:0]       ALUOp;
    logic             Illegal;
    logic [CNT_W-1:0] DecodeCount;

    always #5 Clock = ~Clock;

    inst_decode_stage #(.CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset), .Inst(Inst), .InstValid(InstValid),
        .InstReady(InstReady), .Stall(Stall), .IdValid(IdValid),
        .Op(Op), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Funct(Funct), .Imm16(Imm16),
        .Target(Target), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemToReg(MemToReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .Jump(Jump), .ALUOp(ALUOp), .Illegal(Illegal),
        .DecodeCount(DecodeCount)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0]      word;
        logic             vld;
        logic [9:0]       ctrl;
        logic             ill;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    // Reference model state. m_st: 0 = run, 1 = squash, 2 = halt.
    logic [31:0]      m_word;
    logic             m_vld;
    logic [9:0]       m_ctrl;
    logic             m_ill;
    logic [CNT_W-1:0] m_cnt;
    int               m_st;
    bit               m_known = 0;

    // Returns {legal, RegDst ALUSrc MemToReg RegWrite MemRead MemWrite Branch Jump ALUOp}.
    function automatic logic [10:0] ref_dec(input logic [31:0] w);
        case (w[31:26])
            6'h00: begin
                case (w[5:0])
                    6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00: return 11'b1_1001000010;
                    default: return 11'b0;
                endcase
            end
            6'h23: return 11'b1_0111100000;
            6'h2b: return 11'b1_0100010000;
            6'h04: return 11'b1_0000001001;
            6'h02: return 11'b1_0000000100;
            6'h08: return 11'b1_0101000000;
            6'h0d: return 11'b1_0101000011;
            default: return 11'b0;
        endcase
    endfunction

    task automatic step(input logic r, input logic v, input logic [31:0] w, input logic s);
        logic [10:0] d;
        exp_t        e;
        Reset = r; InstValid = v; Inst = w; Stall = s;
        #1;
        if (m_known) chk("ready", 64'(InstReady), 64'(!s && m_st != 2));
        if (r) begin
            m_word = '0; m_vld = 0; m_ctrl = '0; m_ill = 0; m_cnt = '0; m_st = 0;
            m_known = 1;
        end else if (s) begin
            // hold
        end else if (m_st == 2 || !v) begin
            m_vld = 0; m_ctrl = '0;
        end else begin
            m_word = w; m_vld = 0; m_ctrl = '0;
            if (m_st == 1) begin
                m_st = 0;
            end else begin
                d = ref_dec(w);
                if (!d[10]) begin
                    m_ill = 1; m_st = 2;
                end else begin
                    m_vld = 1; m_ctrl = d[9:0]; m_cnt = m_cnt + 1'b1;
`ifndef DELAY_SLOT_EN
                    if (d[3] || d[2]) m_st = 1;
`endif
                end
            end
        end
        e = '{word: m_word, vld: m_vld, ctrl: m_ctrl, ill: m_ill, cnt: m_cnt};
        sb.push_back(e);
        @(posedge Clock);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("word", 64'({Op, Target}), 64'(e.word));
            chk("fields", 64'({Rs, Rt, Rd, Funct, Imm16}),
                64'({e.word[25:21], e.word[20:16], e.word[15:11], e.word[5:0], e.word[15:0]}));
            chk("idvalid", 64'(IdValid), 64'(e.vld));
            chk("ctrl", 64'({RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite,
                             Branch, Jump, ALUOp}), 64'(e.ctrl));
            chk("illegal", 64'(Illegal), 64'(e.ill));
            chk("count", 64'(DecodeCount), 64'(e.cnt));
        end
    endtask

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_SUB  = 32'h00221822;
    localparam logic [31:0] I_BEQ  = 32'h10220003;
    localparam logic [31:0] I_ADDI = 32'h20010005;
    localparam logic [31:0] I_LW   = 32'h8C410004;
    localparam logic [31:0] I_SW   = 32'hAC410008;
    localparam logic [31:0] I_J    = 32'h08000010;
    localparam logic [31:0] I_ORI  = 32'h34210001;
    localparam logic [31:0] I_BAD  = 32'hFC000000;
    localparam logic [31:0] I_BADF = 32'h00221821;

    logic [31:0] pool [0:13];

    initial begin
        Reset = 1; InstValid = 0; Inst = '0; Stall = 0;

        // Reset state.
        step(1, 0, 32'h0, 0);
        step(1, 0, 32'h0, 0);
        chk("rst_ready", 64'(InstReady), 64'd1);

        // add $3,$1,$2
        step(0, 1, I_ADD, 0);
        chk("add_rs", 64'(Rs), 64'd1);
        chk("add_rt", 64'(Rt), 64'd2);
        chk("add_rd", 64'(Rd), 64'd3);
        chk("add_aluop", 64'(ALUOp), 64'd2);
        chk("add_cnt", 64'(DecodeCount), 64'd1);
        step(0, 0, 32'h0, 0);

        // beq followed by addi.
        step(1, 0, 32'h0, 0);
        step(0, 1, I_BEQ, 0);
        chk("beq_branch", 64'(Branch), 64'd1);
        chk("beq_imm", 64'(Imm16), 64'h3);
        step(0, 1, I_ADDI, 0);
`ifdef DELAY_SLOT_EN
        chk("slot_vld", 64'(IdValid), 64'd1);
        chk("slot_alusrc", 64'(ALUSrc), 64'd1);
        chk("slot_cnt", 64'(DecodeCount), 64'd2);
`else
        chk("slot_vld", 64'(IdValid), 64'd0);
        chk("slot_regwrite", 64'(RegWrite), 64'd0);
        chk("slot_cnt", 64'(DecodeCount), 64'd1);
`endif

        // lw with a 3-cycle stall after accept, then release.
        step(0, 1, I_LW, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, I_SUB, 1);
            chk("stall_memread", 64'(MemRead), 64'd1);
            chk("stall_imm", 64'(Imm16), 64'h4);
        end
        step(0, 1, I_SUB, 0);
        step(0, 1, I_SW, 0);

        // Bubble, then squash of an illegal word (no halt without delay slot).
        step(0, 0, I_ADD, 0);
        step(0, 1, I_J, 0);
        step(0, 1, I_BAD, 0);
        step(0, 1, I_BADF, 0);
        chk("illegal_funct", 64'(Illegal), 64'd1);
        step(1, 0, 32'h0, 0);

        // Illegal opcode: halt until reset.
        step(0, 1, I_BAD, 0);
        chk("halt_ill", 64'(Illegal), 64'd1);
        for (int i = 0; i < 3; i++) step(0, 1, I_ADD, 0);
        chk("halt_ready", 64'(InstReady), 64'd0);
        step(0, 1, I_ADD, 1);
        step(1, 1, I_ADD, 0);
        chk("halt_clr_ill", 64'(Illegal), 64'd0);
        chk("halt_clr_ready", 64'(InstReady), 64'd1);

        // Reset during SQUASH cancels the squash.
        step(0, 1, I_J, 0);
        chk("j_jump", 64'(Jump), 64'd1);
        step(1, 1, I_ADD, 0);
        chk("rst_jump", 64'(Jump), 64'd0);
        step(0, 1, I_ADD, 0);
        chk("post_rst_vld", 64'(IdValid), 64'd1);
        chk("post_rst_jump", 64'(Jump), 64'd0);

        // Counter wrap with CNT_W=4.
        step(1, 0, 32'h0, 0);
        for (int i = 0; i < 17; i++) begin
            step(0, 1, I_ORI, 0);
            chk("ori_aluop", 64'(ALUOp), 64'd3);
            chk("ori_cnt", 64'(DecodeCount), 64'((i + 1) % 16));
        end

        // Random mix.
        pool[0] = I_ADD;  pool[1] = I_SUB;  pool[2] = 32'h00221824; pool[3] = 32'h00221825;
        pool[4] = 32'h0022182A; pool[5] = 32'h00000000; pool[6] = I_LW; pool[7] = I_SW;
        pool[8] = I_BEQ;  pool[9] = I_J;    pool[10] = I_ADDI; pool[11] = I_ORI;
        pool[12] = I_BAD; pool[13] = I_BADF;
        for (int i = 0; i < 300; i++) begin
            logic [31:0] w;
            int          k;
            k = ($urandom_range(0, 19) == 0) ? $urandom_range(12, 13) : $urandom_range(0, 11);
            w = pool[k];
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), w,
                 ($urandom_range(0, 4) == 0));
        end

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
